// File: rtl/qpsk_symbol_demapper_if.sv
// Handshake bundle between the zero-pad-removal stage, the QPSK demapper and the bit de-interleaver.
// The slave modport is the demapper side; master is the side that drives it.
interface qpsk_symbol_demapper_if #(
    parameter int NSC = 4,
    parameter int SW  = 16
);
    localparam int KW = (NSC > 1) ? $clog2(NSC) : 1;

    logic                in_valid;
    logic                in_ready;
    logic [NSC*SW-1:0]   in_inphase;
    logic [NSC*SW-1:0]   in_quad;
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_bits;
    logic [KW-1:0]       out_index;
    logic                out_last;
    logic                out_erase;

    modport master (
        output in_valid, in_inphase, in_quad, out_ready,
        input  in_ready, out_valid, out_bits, out_index, out_last, out_erase
    );

    modport slave (
        input  in_valid, in_inphase, in_quad, out_ready,
        output in_ready, out_valid, out_bits, out_index, out_last, out_erase
    );
endinterface

// File: rtl/qpsk_symbol_demapper.sv
// Buffers one OFDM symbol and emits a Gray-coded hard-decision QPSK pair per subcarrier per cycle.
// Optional erasure flagging of low-magnitude samples: define QPSK_ERASURE_DETECT_EN.
module qpsk_symbol_demapper #(
    parameter int             NSC    = 4,
    parameter int             SW     = 16,
    parameter logic [SW-1:0]  THRESH = 16'd4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    qpsk_symbol_demapper_if.slave   bus,
    output logic [15:0]             frame_count
);
    localparam int KW = (NSC > 1) ? $clog2(NSC) : 1;

    typedef enum logic {IDLE, EMIT} state_t;

    typedef struct packed {
        logic [1:0] bits;
        logic       erase;
    } beat_t;

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [NSC-1:0][SW-1:0]  smp_i_q, smp_i_d;
    logic [NSC-1:0][SW-1:0]  smp_q_q, smp_q_d;
    beat_t                   beat_q, beat_d;
    logic [15:0]             fc_q, fc_d;
    logic                    last_k;
    logic                    in_fire;

`ifdef QPSK_ERASURE_DETECT_EN
    // One extra bit so that the most negative sample negates to a large magnitude.
    function automatic logic is_weak(input logic [SW-1:0] s);
        logic [SW:0] ext;
        logic [SW:0] mag;
        ext = {s[SW-1], s};
        mag = s[SW-1] ? -ext : ext;
        return mag < {1'b0, THRESH};
    endfunction
`endif

    assign last_k       = (k_q == KW'(NSC - 1));
    // Accepting on the final beat lets the next symbol follow without a bubble.
    assign bus.in_ready = (state_q == IDLE) || (last_k && bus.out_ready);
    assign in_fire      = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        smp_i_d = smp_i_q;
        smp_q_d = smp_q_q;
        fc_d    = fc_q;
        if (state_q == EMIT && bus.out_ready) begin
            if (!last_k) begin
                k_d = k_q + 1'b1;
            end else begin
                fc_d    = fc_q + 16'd1;
                k_d     = '0;
                state_d = IDLE;
            end
        end
        if (in_fire) begin
            smp_i_d = bus.in_inphase;
            smp_q_d = bus.in_quad;
            k_d     = '0;
            state_d = EMIT;
        end
        // Decide on the sample that will be presented after this edge.
        beat_d = '0;
        if (state_d == EMIT) begin
            beat_d.bits = {smp_i_d[k_d][SW-1], smp_q_d[k_d][SW-1]};
`ifdef QPSK_ERASURE_DETECT_EN
            beat_d.erase = is_weak(smp_i_d[k_d]) || is_weak(smp_q_d[k_d]);
`else
            beat_d.erase = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            fc_q    <= fc_d;
        end
    end

    // Symbol buffer needs no reset; it is only read in EMIT after a load.
    always_ff @(posedge clk) begin
        smp_i_q <= smp_i_d;
        smp_q_q <= smp_q_d;
    end

    assign bus.out_valid = (state_q == EMIT);
    assign bus.out_bits  = beat_q.bits;
    assign bus.out_index = k_q;
    assign bus.out_last  = (state_q == EMIT) && last_k;
    assign bus.out_erase = beat_q.erase;
    assign frame_count   = fc_q;
endmodule
